imem_loader: RTL and testbench

//  Writer side of the instruction memory. Receives a byte stream over a valid/ready handshake
//  and assembles big-endian 32-bit words (MSB byte first, matching memfile.dat word order).

---
 rtl/imem_loader_pkg.sv | 16 +
 rtl/imem_loader_if.sv | 20 ++
 rtl/imem_loader_byte_packer.sv | 47 ++++
 rtl/imem_loader.sv | 177 +++++++++++++++++
 tb/tb_imem_loader.sv | 278 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
package imem_loader_pkg;

    localparam int unsigned BYTES_PER_WORD = 4;
    localparam int unsigned ADDR_W_DEF     = 6;
    localparam int unsigned DATA_W_DEF     = 32;

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        DATA,
        CSUM,
        DONE
    } state_t;

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream valid/ready handshake feeding the instruction-memory loader.
interface imem_loader_if;

    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;

    modport master (
        output in_data,
        output in_valid,
        input  in_ready
    );

    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready
    );

endinterface

// File: rtl/imem_loader_byte_packer.sv
// Shifts accepted bytes MSB-first into a word; word_valid flags the byte completing a word.
module byte_packer
    import imem_loader_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              in_valid,
    input  logic [7:0]        in_byte,
    output logic [DATA_W-1:0] word,
    output logic              word_valid
);

    localparam int unsigned IDX_W = $clog2(BYTES_PER_WORD);

    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [DATA_W-9:0] shift_q, shift_d;

    // word is combinational so the owner can register it in the same cycle as byte 3
    always_comb begin
        idx_d      = idx_q;
        shift_d    = shift_q;
        word       = {shift_q, in_byte};
        word_valid = 1'b0;
        if (clear) begin
            idx_d   = '0;
            shift_d = '0;
        end else if (in_valid) begin
            idx_d      = idx_q + 1'b1;
            shift_d    = word[DATA_W-9:0];
            word_valid = (idx_q == IDX_W'(BYTES_PER_WORD - 1));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q   <= '0;
            shift_q <= '0;
        end else begin
            idx_q   <= idx_d;
            shift_q <= shift_d;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Instruction-memory loader: header byte N, then N+1 big-endian words written to imem.
// Optional trailing checksum word enabled by IMEM_LOADER_CHECKSUM_EN.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    imem_loader_if.slave      stream,
    output logic              we,
    output logic [ADDR_W-1:0] wa,
    output logic [DATA_W-1:0] wd,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              cpu_hold
);

`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam state_t AFTER_DATA = CSUM;
`else
    localparam state_t AFTER_DATA = DONE;
`endif

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] n_q, n_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] wa_q, wa_d;
    logic [DATA_W-1:0] wd_q, wd_d;

    logic              busy_c;
    logic              in_ready_c;
    logic              accept;
    logic              pk_clear;
    logic              pk_valid;
    logic [DATA_W-1:0] pk_word;
    logic              pk_word_valid;

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [DATA_W-1:0] sum_q, sum_d;
    logic              err_q, err_d;
`endif

    // abort masks in_ready so a byte offered in the abort cycle is never consumed
    always_comb begin
        busy_c     = (state_q == HDR) || (state_q == DATA) || (state_q == CSUM);
        in_ready_c = busy_c && !abort;
        accept     = stream.in_valid && in_ready_c;
        pk_valid   = accept && ((state_q == DATA) || (state_q == CSUM));
    end

    assign stream.in_ready = in_ready_c;

    byte_packer #(
        .DATA_W(DATA_W)
    ) u_packer (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (pk_clear),
        .in_valid  (pk_valid),
        .in_byte   (stream.in_data),
        .word      (pk_word),
        .word_valid(pk_word_valid)
    );

    always_comb begin
        state_d  = state_q;
        n_d      = n_q;
        cnt_d    = cnt_q;
        we_d     = 1'b0;
        wa_d     = wa_q;
        wd_d     = wd_q;
        pk_clear = 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
        sum_d    = sum_q;
        err_d    = err_q;
`endif
        if (abort) begin
            state_d  = IDLE;
            cnt_d    = '0;
            pk_clear = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
            err_d    = 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        state_d  = HDR;
                        cnt_d    = '0;
                        pk_clear = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        sum_d    = '0;
                        err_d    = 1'b0;
`endif
                    end
                end
                HDR: begin
                    if (accept) begin
                        n_d     = ADDR_W'(stream.in_data);
                        state_d = DATA;
                    end
                end
                DATA: begin
                    if (pk_word_valid) begin
                        we_d = 1'b1;
                        wa_d = cnt_q;
                        wd_d = pk_word;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        sum_d = sum_q + pk_word;
`endif
                        if (cnt_q == n_q) begin
                            state_d = AFTER_DATA;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end
`ifdef IMEM_LOADER_CHECKSUM_EN
                CSUM: begin
                    if (pk_word_valid) begin
                        err_d   = ((sum_q + pk_word) != '0);
                        state_d = DONE;
                    end
                end
`endif
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            n_q     <= '0;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            wa_q    <= '0;
            wd_q    <= '0;
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            wa_q    <= wa_d;
            wd_q    <= wd_d;
        end
    end

`ifdef IMEM_LOADER_CHECKSUM_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q <= '0;
            err_q <= 1'b0;
        end else begin
            sum_q <= sum_d;
            err_q <= err_d;
        end
    end
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    assign we       = we_q;
    assign wa       = wa_q;
    assign wd       = wd_q;
    assign busy     = busy_c;
    assign cpu_hold = busy_c;
    assign done     = (state_q == DONE);

endmodule

// File: tb/tb_imem_loader.sv
// Directed self-checking bench for imem_loader; checksum test runs when IMEM_LOADER_CHECKSUM_EN is defined.
module tb_imem_loader;

    localparam int unsigned ADDR_W = 6;
    localparam int unsigned DATA_W = 32;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic              abort = 1'b0;
    logic              we;
    logic [ADDR_W-1:0] wa;
    logic [DATA_W-1:0] wd;
    logic              busy, done, err, cpu_hold;

    int checks = 0;
    int errors = 0;

    logic [ADDR_W-1:0] wa_log[$];
    logic [DATA_W-1:0] wd_log[$];

    imem_loader_if sif ();

    imem_loader #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .abort   (abort),
        .stream  (sif.slave),
        .we      (we),
        .wa      (wa),
        .wd      (wd),
        .busy    (busy),
        .done    (done),
        .err     (err),
        .cpu_hold(cpu_hold)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst_n && we) begin
            wa_log.push_back(wa);
            wd_log.push_back(wd);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic pulse_abort();
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
    endtask

    // Called at a negedge; returns at the negedge after the byte was taken
    task automatic send_byte(input logic [7:0] b);
        int t = 0;
        sif.in_data  = b;
        sif.in_valid = 1'b1;
        #1;
        while (!sif.in_ready && t < 50) begin
            @(negedge clk);
            #1;
            t++;
        end
        if (!sif.in_ready) check("send_timeout", 32'd0, 32'd1);
        @(negedge clk);
        sif.in_valid = 1'b0;
    endtask

    task automatic wait_done();
        int t = 0;
        while (!done && t < 40) begin
            @(negedge clk);
            t++;
        end
        check("wait_done", {31'd0, done}, 32'd1);
    endtask

    task automatic clear_log();
        wa_log.delete();
        wd_log.delete();
    endtask

    logic [7:0] basic[9] = '{8'h01, 8'h20, 8'h08, 8'h00, 8'h05, 8'h8C, 8'h09, 8'h00, 8'h00};
    int         gaps[9]  = '{0, 2, 1, 0, 3, 1, 0, 2, 1};

    initial begin
        logic [31:0] exp_w;
        logic [7:0]  i8;
        sif.in_data  = 8'h00;
        sif.in_valid = 1'b0;

        // reset state
        idle(2);
        check("rst_in_ready", {31'd0, sif.in_ready}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_we", {31'd0, we}, 32'd0);
        check("rst_cpu_hold", {31'd0, cpu_hold}, 32'd0);
        rst_n = 1'b1;
        idle(2);

        // bytes offered while idle are not taken
        sif.in_valid = 1'b1;
        sif.in_data  = 8'h55;
        #1;
        check("idle_in_ready", {31'd0, sif.in_ready}, 32'd0);
        @(negedge clk);
        sif.in_valid = 1'b0;

        // basic stream at 1 byte/clk
        pulse_start();
        check("hdr_busy", {31'd0, busy}, 32'd1);
        check("hdr_cpu_hold", {31'd0, cpu_hold}, 32'd1);
        for (int i = 0; i < 9; i++) send_byte(basic[i]);
        wait_done();
        idle(2);
        check("basic_nwr", wa_log.size(), 32'd2);
        if (wa_log.size() == 2) begin
            check("basic_wa0", {26'd0, wa_log[0]}, 32'd0);
            check("basic_wd0", wd_log[0], 32'h20080005);
            check("basic_wa1", {26'd0, wa_log[1]}, 32'd1);
            check("basic_wd1", wd_log[1], 32'h8C090000);
        end
        check("basic_busy", {31'd0, busy}, 32'd0);
        check("basic_cpu_hold", {31'd0, cpu_hold}, 32'd0);
        check("basic_in_ready", {31'd0, sif.in_ready}, 32'd0);
        check("basic_err", {31'd0, err}, 32'd0);
        clear_log();

        // same stream with bubbles; start in DONE reloads
        pulse_start();
        check("reload_done_clr", {31'd0, done}, 32'd0);
        for (int i = 0; i < 9; i++) begin
            idle(gaps[i]);
            send_byte(basic[i]);
        end
        wait_done();
        idle(2);
        check("bub_nwr", wa_log.size(), 32'd2);
        if (wa_log.size() == 2) begin
            check("bub_wa0", {26'd0, wa_log[0]}, 32'd0);
            check("bub_wd0", wd_log[0], 32'h20080005);
            check("bub_wa1", {26'd0, wa_log[1]}, 32'd1);
            check("bub_wd1", wd_log[1], 32'h8C090000);
        end
        clear_log();

        // full depth: 64 words
        pulse_start();
        send_byte(8'h3F);
        for (int i = 0; i < 64; i++) begin
            i8 = 8'(i);
            send_byte(i8);
            send_byte(8'hA5);
            send_byte(~i8);
            send_byte(i8 + 8'd1);
        end
        wait_done();
        idle(2);
        check("full_nwr", wa_log.size(), 32'd64);
        if (wa_log.size() == 64) begin
            for (int i = 0; i < 64; i++) begin
                i8    = 8'(i);
                exp_w = {i8, 8'hA5, ~i8, i8 + 8'd1};
                check($sformatf("full_wa%0d", i), {26'd0, wa_log[i]}, i);
                check($sformatf("full_wd%0d", i), wd_log[i], exp_w);
            end
        end
        check("full_last_wa", {26'd0, wa}, 32'd63);
        clear_log();

        // abort after 6 data bytes
        pulse_start();
        send_byte(8'h02);
        for (int i = 0; i < 6; i++) send_byte(8'h10 + 8'(i));
        pulse_abort();
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_done", {31'd0, done}, 32'd0);
        check("abort_in_ready", {31'd0, sif.in_ready}, 32'd0);
        idle(3);
        check("abort_nwr", wa_log.size(), 32'd1);
        if (wa_log.size() == 1) begin
            check("abort_wa0", {26'd0, wa_log[0]}, 32'd0);
            check("abort_wd0", wd_log[0], 32'h10111213);
        end
        clear_log();

        // start while busy ignored: partial word must survive
        pulse_start();
        send_byte(8'h00);
        send_byte(8'hDE);
        send_byte(8'hAD);
        pulse_start();
        check("busy_start_busy", {31'd0, busy}, 32'd1);
        send_byte(8'hBE);
        send_byte(8'hEF);
        wait_done();
        idle(2);
        check("busy_start_nwr", wa_log.size(), 32'd1);
        if (wa_log.size() == 1) check("busy_start_wd", wd_log[0], 32'hDEADBEEF);
        clear_log();

        // reset mid-DATA clears outputs asynchronously
        pulse_start();
        send_byte(8'h03);
        for (int i = 0; i < 10; i++) send_byte(8'h11 * 8'(i + 1));
        check("pre_rst_busy", {31'd0, busy}, 32'd1);
        check("pre_rst_wa", {26'd0, wa}, 32'd1);
        check("pre_rst_wd", wd, 32'h55667788);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_busy", {31'd0, busy}, 32'd0);
        check("arst_in_ready", {31'd0, sif.in_ready}, 32'd0);
        check("arst_wa", {26'd0, wa}, 32'd0);
        check("arst_wd", wd, 32'd0);
        check("arst_cpu_hold", {31'd0, cpu_hold}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        idle(2);
        check("post_rst_busy", {31'd0, busy}, 32'd0);
        check("post_rst_done", {31'd0, done}, 32'd0);
        clear_log();

`ifdef IMEM_LOADER_CHECKSUM_EN
        // checksum good: 1 + 2 + FFFFFFFD == 0
        pulse_start();
        send_byte(8'h01);
        foreach (basic[k]) begin end
        send_byte(8'h00); send_byte(8'h00); send_byte(8'h00); send_byte(8'h01);
        send_byte(8'h00); send_byte(8'h00); send_byte(8'h00); send_byte(8'h02);
        send_byte(8'hFF); send_byte(8'hFF); send_byte(8'hFF); send_byte(8'hFD);
        wait_done();
        check("csum_good_err", {31'd0, err}, 32'd0);
        idle(2);
        check("csum_nwr", wa_log.size(), 32'd2);
        clear_log();

        // checksum bad
        pulse_start();
        send_byte(8'h01);
        send_byte(8'h00); send_byte(8'h00); send_byte(8'h00); send_byte(8'h01);
        send_byte(8'h00); send_byte(8'h00); send_byte(8'h00); send_byte(8'h02);
        send_byte(8'h00); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
        wait_done();
        check("csum_bad_err", {31'd0, err}, 32'd1);
        pulse_start();
        check("csum_err_clr", {31'd0, err}, 32'd0);
        pulse_abort();
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
